apb_master_bridge: RTL and testbench
====================================

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameters: BUS_WIDTH, default 16, address width; DATA_WIDTH, default 16, data width; TIMEOUT, default 255, maximum ACCESS cycles before abort (legal range 1..255).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  core requests a transfer.
REQ-005 req_ready  output  1  bridge accepts request this cycle.
REQ-006 req_addr  input  BUS_WIDTH  transfer address.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_wdata  input  DATA_WIDTH  write data.
REQ-009 resp_valid  output  1  one-cycle completion pulse.
REQ-010 resp_rdata  output  DATA_WIDTH  read data; 0 on write or timeout.
REQ-011 resp_timeout  output  1  qualifies resp_valid; transfer aborted.
REQ-012 M_PADDR  output  BUS_WIDTH  APB address.
REQ-013 M_PWRITE  output  1  APB direction.
REQ-014 M_PSELx  output  1  APB select toward interconnect.
REQ-015 M_PENABLE  output  1  APB enable.
REQ-016 M_PWDATA  output  DATA_WIDTH  APB write data.
REQ-017 M_PRDATA  input  DATA_WIDTH  APB read data.
REQ-018 M_PREADY  input  1  APB transfer complete.

Function
REQ-019 FSM states SHALL be IDLE, SETUP and ACCESS, held in a registered state variable.
REQ-020 req_ready SHALL equal (state == IDLE); it SHALL be combinational from state only.
REQ-021 In IDLE, req_valid && req_ready SHALL capture addr/write/wdata into holding registers and move to SETUP next edge.
REQ-022 SETUP: M_PSELx=1, M_PENABLE=0; unconditional transition to ACCESS next edge.
REQ-023 ACCESS: M_PSELx=1, M_PENABLE=1; M_PREADY=1 -> IDLE next edge; otherwise remain in ACCESS.
REQ-024 M_PADDR, M_PWRITE and M_PWDATA SHALL be driven from the holding registers and stay constant from SETUP through the last ACCESS cycle.
REQ-025 On M_PREADY=1 in ACCESS, the next edge SHALL register resp_valid=1, resp_timeout=0, resp_rdata=M_PRDATA on a read or 0 on a write.
REQ-026 Wait counter (8 bit) SHALL clear on entry to ACCESS and increment each ACCESS cycle with M_PREADY=0.
REQ-027 When the counter reaches TIMEOUT-1 with M_PREADY=0, the next edge SHALL go to IDLE with resp_valid=1, resp_timeout=1, resp_rdata=0.
REQ-028 If M_PREADY=1 in the same cycle as the timeout condition, normal completion (REQ-025) SHALL win.
REQ-029 resp_valid SHALL last exactly one cycle; resp_rdata/resp_timeout hold their values until the next response.
REQ-030 Minimum latency: accept at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, resp_valid in cycle N+3 when M_PREADY=1 at first ACCESS.
REQ-031 M_PSELx and M_PENABLE SHALL both be 0 in IDLE; the earliest next SETUP is the cycle after resp_valid.

Reset
REQ-032 On rst: state=IDLE, M_PSELx=0, M_PENABLE=0, resp_valid=0, resp_timeout=0, resp_rdata=0, counter=0, holding registers=0.
REQ-033 rst during SETUP or ACCESS SHALL abort the transfer with no resp_valid; req_ready=1 the cycle after reset deasserts.

Structure
REQ-034 Shared package `vmicro16_apb_pkg` SHALL hold the state encodings (IDLE=0, SETUP=1, ACCESS=2) and the default TIMEOUT constant.
REQ-035 The wait counter and its compare SHALL be a sub-module `apb_wait_timer` (inputs clear/enable, output expired).

Verification
REQ-036 Read 0x0010, M_PREADY=1 at first ACCESS, M_PRDATA=0xBEEF -> resp_valid in cycle N+3, resp_rdata=0xBEEF, resp_timeout=0.
REQ-037 Write 0x0020 with data 0x1234, M_PREADY held 0 for 3 ACCESS cycles -> PADDR/PWDATA stable for 5 cycles, resp_rdata=0, no timeout.
REQ-038 TIMEOUT=4, M_PREADY never asserted -> 4 ACCESS cycles, then resp_valid=1, resp_timeout=1, M_PSELx=0.
REQ-039 TIMEOUT=4, M_PREADY=1 on 4th ACCESS cycle -> normal completion, resp_timeout=0.
REQ-040 rst asserted in ACCESS of read 0x0030 -> next cycle M_PSELx=0, M_PENABLE=0, no resp_valid, req_ready=1 after release.
REQ-041 req_valid held high for two back-to-back requests -> req_ready=0 during SETUP/ACCESS, second SETUP begins the cycle after the first resp_valid.

Source files
------------

// File: rtl/apb_master_bridge_pkg.sv
// ============================================================================
// Module : vmicro16_apb_pkg
// Brief  : State encodings and shared constants for the APB master bridge.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vmicro16_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned C_DEFAULT_TIMEOUT = 255;
  localparam int unsigned C_WAIT_CNT_W      = 8;

endpackage : vmicro16_apb_pkg

`default_nettype wire

// File: rtl/apb_master_bridge_if.sv
// ============================================================================
// Module : apb_master_bridge_if
// Brief  : Core request/response channel plus APB master signals of the bridge.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_master_bridge_if #(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 16
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic [BUS_WIDTH-1:0]  req_addr;
  logic                  req_write;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_timeout;

  logic [BUS_WIDTH-1:0]  M_PADDR;
  logic                  M_PWRITE;
  logic                  M_PSELx;
  logic                  M_PENABLE;
  logic [DATA_WIDTH-1:0] M_PWDATA;
  logic [DATA_WIDTH-1:0] M_PRDATA;
  logic                  M_PREADY;

  // Bridge side: accepts core requests, drives the APB bus.
  modport master (
    input  req_valid, req_addr, req_write, req_wdata, M_PRDATA, M_PREADY,
    output req_ready, resp_valid, resp_rdata, resp_timeout,
           M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
  );

  // Environment side: issues core requests and answers as the APB slave.
  modport slave (
    output req_valid, req_addr, req_write, req_wdata, M_PRDATA, M_PREADY,
    input  req_ready, resp_valid, resp_rdata, resp_timeout,
           M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
  );

endinterface : apb_master_bridge_if

`default_nettype wire

// File: rtl/apb_master_bridge_wait_timer.sv
// ============================================================================
// Module : apb_wait_timer
// Brief  : 8-bit ACCESS wait counter; flags expiry at TIMEOUT-1 wait cycles.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_wait_timer
  import vmicro16_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = C_DEFAULT_TIMEOUT
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear,
  input  wire logic enable,
  output logic      expired
);

  localparam logic [C_WAIT_CNT_W-1:0] C_LIMIT = C_WAIT_CNT_W'(TIMEOUT - 1);

  logic [C_WAIT_CNT_W-1:0] count_q;
  logic [C_WAIT_CNT_W-1:0] count_d;

  // The transfer ends once expired is seen, so the count never wraps.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == C_LIMIT);

endmodule : apb_wait_timer

`default_nettype wire

// File: rtl/apb_master_bridge.sv
// ============================================================================
// Module : apb_master_bridge
// Brief  : Single-outstanding core-to-APB master bridge with ACCESS timeout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_bridge
  import vmicro16_apb_pkg::*;
#(
  parameter int          BUS_WIDTH  = 16,
  parameter int          DATA_WIDTH = 16,
  parameter int unsigned TIMEOUT    = C_DEFAULT_TIMEOUT
) (
  input wire logic            clk,
  input wire logic            rst,
  apb_master_bridge_if.master bus
);

  apb_state_e            state_q, state_d;
  logic [BUS_WIDTH-1:0]  addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_timeout_q, resp_timeout_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic w_timer_clear;
  logic w_timer_en;
  logic w_timer_expired;

  // Counter is cleared while in SETUP so it reads zero on the first ACCESS cycle.
  assign w_timer_clear = (state_q == SETUP);
  assign w_timer_en    = (state_q == ACCESS) && !bus.M_PREADY;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_timer_clear),
    .enable  (w_timer_en),
    .expired (w_timer_expired)
  );

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    write_d        = write_q;
    wdata_d        = wdata_q;
    psel_d         = psel_q;
    penable_d      = penable_q;
    resp_valid_d   = 1'b0;
    resp_timeout_d = resp_timeout_q;
    resp_rdata_d   = resp_rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d    = bus.req_addr;
          write_d   = bus.req_write;
          wdata_d   = bus.req_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // A slave completing on the timeout cycle still counts as a normal finish.
        if (bus.M_PREADY) begin
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b0;
          resp_rdata_d   = write_q ? '0 : bus.M_PRDATA;
          state_d        = IDLE;
        end else if (w_timer_expired) begin
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b1;
          resp_rdata_d   = '0;
          state_d        = IDLE;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      write_q        <= 1'b0;
      wdata_q        <= '0;
      psel_q         <= 1'b0;
      penable_q      <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_rdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      write_q        <= write_d;
      wdata_q        <= wdata_d;
      psel_q         <= psel_d;
      penable_q      <= penable_d;
      resp_valid_q   <= resp_valid_d;
      resp_timeout_q <= resp_timeout_d;
      resp_rdata_q   <= resp_rdata_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.M_PADDR      = addr_q;
  assign bus.M_PWRITE     = write_q;
  assign bus.M_PWDATA     = wdata_q;
  assign bus.M_PSELx      = psel_q;
  assign bus.M_PENABLE    = penable_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_timeout = resp_timeout_q;
  assign bus.resp_rdata   = resp_rdata_q;

endmodule : apb_master_bridge

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
// ============================================================================
// Module : tb_apb_master_bridge
// Brief  : Scoreboard bench for apb_master_bridge with a scripted APB slave.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master_bridge;

  localparam int C_TIMEOUT = 4;
  localparam int C_NEVER   = 255;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        tmo;
    int          acc;
  } exp_t;

  typedef struct {
    int          waits;
    logic [15:0] prdata;
  } slv_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_resp_cyc = 0;
  int   setup_cyc = 0;

  exp_t exp_q[$];
  slv_t slave_q[$];

  apb_master_bridge_if #(.BUS_WIDTH(16), .DATA_WIDTH(16)) bus ();

  apb_master_bridge #(
    .BUS_WIDTH  (16),
    .DATA_WIDTH (16),
    .TIMEOUT    (C_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // APB slave: holds PREADY low for 'waits' ACCESS cycles, then completes.
  initial begin
    slv_t cfg;
    int   acc;
    cfg = '{waits: 0, prdata: 16'h0};
    acc = 0;
    bus.M_PREADY = 1'b0;
    bus.M_PRDATA = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (bus.M_PSELx && !bus.M_PENABLE) begin
        if (slave_q.size() > 0) cfg = slave_q.pop_front();
        acc = 0;
        bus.M_PREADY = 1'b0;
        bus.M_PRDATA = 16'hDEAD;
      end else if (bus.M_PSELx && bus.M_PENABLE) begin
        bus.M_PREADY = (acc == cfg.waits);
        bus.M_PRDATA = (acc == cfg.waits) ? cfg.prdata : 16'hDEAD;
        acc++;
      end else begin
        bus.M_PREADY = 1'b0;
        bus.M_PRDATA = 16'hDEAD;
      end
    end
  end

  // Monitor: bus stability against the in-flight entry, response scoreboard.
  initial begin
    exp_t e;
    int   acc_seen;
    logic prev_resp;
    acc_seen  = 0;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_seen  = 0;
        prev_resp = 1'b0;
      end else begin
        chk("req_ready_idle", 32'(bus.req_ready), 32'(!bus.M_PSELx));
        if (bus.M_PSELx && exp_q.size() > 0) begin
          chk("paddr_stable", 32'(bus.M_PADDR), 32'(exp_q[0].addr));
          chk("pwrite_stable", 32'(bus.M_PWRITE), 32'(exp_q[0].wr));
          if (exp_q[0].wr) chk("pwdata_stable", 32'(bus.M_PWDATA), 32'(exp_q[0].wdata));
        end
        if (bus.M_PSELx && bus.M_PENABLE) acc_seen++;
        if (bus.resp_valid) begin
          chk("resp_one_cycle", 32'(prev_resp), 32'd0);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_resp: got resp_valid=1, expected no response (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("resp_rdata", 32'(bus.resp_rdata), 32'(e.rdata));
            chk("resp_timeout", 32'(bus.resp_timeout), 32'(e.tmo));
            chk("access_cycles", 32'(acc_seen), 32'(e.acc));
            chk("psel_at_resp", 32'(bus.M_PSELx), 32'd0);
            last_resp_cyc = cyc;
          end
          acc_seen = 0;
        end
        prev_resp = bus.resp_valid;
      end
    end
  end

  // Called just after a negedge; returns in the SETUP cycle of this request.
  task automatic issue(input logic [15:0] addr, input logic wr, input logic [15:0] wdata,
                       input int waits, input logic [15:0] prdata,
                       input logic [15:0] exp_rdata, input logic exp_tmo, input int exp_acc,
                       input bit keep);
    int n;
    exp_q.push_back('{addr: addr, wr: wr, wdata: wdata, rdata: exp_rdata, tmo: exp_tmo, acc: exp_acc});
    slave_q.push_back('{waits: waits, prdata: prdata});
    bus.req_addr  = addr;
    bus.req_write = wr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready=0 for %0d cycles, expected 1", n);
    end
    @(negedge clk);
    chk("setup_psel", 32'(bus.M_PSELx), 32'd1);
    chk("setup_penable", 32'(bus.M_PENABLE), 32'd0);
    setup_cyc = cyc;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending responses, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int su;
    bus.req_valid = 1'b0;
    bus.req_addr  = 16'h0;
    bus.req_write = 1'b0;
    bus.req_wdata = 16'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_psel", 32'(bus.M_PSELx), 32'd0);
    chk("rst_penable", 32'(bus.M_PENABLE), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_timeout", 32'(bus.resp_timeout), 32'd0);
    chk("rst_resp_rdata", 32'(bus.resp_rdata), 32'd0);
    chk("rst_paddr", 32'(bus.M_PADDR), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait read: response two cycles after SETUP, data held afterwards.
    issue(16'h0010, 1'b0, 16'h0000, 0, 16'hBEEF, 16'hBEEF, 1'b0, 1, 1'b0);
    su = setup_cyc;
    drain();
    chk("min_latency", 32'(last_resp_cyc - su), 32'd2);
    chk("rdata_hold", 32'(bus.resp_rdata), 32'hBEEF);
    chk("resp_valid_low", 32'(bus.resp_valid), 32'd0);

    // Write with three wait states: five bus cycles, completion on 4th ACCESS.
    issue(16'h0020, 1'b1, 16'h1234, 3, 16'h7777, 16'h0000, 1'b0, 4, 1'b0);
    drain();

    // Slave never responds: abort after TIMEOUT ACCESS cycles.
    issue(16'h0040, 1'b0, 16'h0000, C_NEVER, 16'h5555, 16'h0000, 1'b1, 4, 1'b0);
    drain();
    chk("timeout_hold", 32'(bus.resp_timeout), 32'd1);

    // PREADY on the timeout cycle completes normally.
    issue(16'h0044, 1'b0, 16'h0000, 3, 16'hA5A5, 16'hA5A5, 1'b0, 4, 1'b0);
    drain();
    issue(16'h0048, 1'b1, 16'h9999, C_NEVER, 16'h0000, 16'h0000, 1'b1, 4, 1'b0);
    drain();

    // Reset during ACCESS aborts silently.
    issue(16'h0030, 1'b0, 16'h0000, C_NEVER, 16'h3333, 16'h0000, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("abort_in_access", 32'(bus.M_PENABLE), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("abort_psel", 32'(bus.M_PSELx), 32'd0);
    chk("abort_penable", 32'(bus.M_PENABLE), 32'd0);
    chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_no_resp", 32'(bus.resp_valid), 32'd0);
    repeat (4) @(negedge clk);

    // Back-to-back with req_valid held: second SETUP right after first response.
    issue(16'h0050, 1'b0, 16'h0000, 1, 16'h1111, 16'h1111, 1'b0, 2, 1'b1);
    issue(16'h0054, 1'b1, 16'hCAFE, 0, 16'h0000, 16'h0000, 1'b0, 1, 1'b0);
    chk("b2b_setup_after_resp", 32'(setup_cyc - last_resp_cyc), 32'd1);
    drain();

    issue(16'h0058, 1'b0, 16'h0000, 2, 16'h0F0F, 16'h0F0F, 1'b0, 3, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_apb_master_bridge

`default_nettype wire
